fir_pipe: RTL and testbench

- Parametrised, pipelined, direct-form FIR filter. Successor to the fixed 16-tap, 16-bit `fir`.
- Keeps the same control scheme:
  - `wind` shifts coefficients in serially.
  - `load` preloads the delay line silently.
  - `in_valid` streams samples.
- Adds configurable tap count and widths, a fixed 3-cycle pipeline, arithmetic right-shift with rounding, output saturation and a saturation flag.
- Sits between the sample source and the downstream datapath. There is no backpressure.

---
 rtl/fir_pipe.sv | 142 ++++++++++++++
 tb/tb_fir_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_pipe.sv
// fir_pipe: parametrised direct-form FIR filter with a fixed 3-stage pipeline
// (products, adder tree, round/shift/saturate). Coefficients are wound in
// serially, the delay line can be preloaded silently, and each streamed
// sample produces exactly one output strobe three cycles later.
module fir_pipe #(
  parameter int TAPS   = 16,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                                              clk,
  input  logic                                              rstb,
  input  logic                                              wind,
  input  logic                                              load,
  input  logic                                              in_valid,
  input  logic [((DATA_W > COEF_W) ? DATA_W : COEF_W)-1:0]  data,
  output logic                                              out_valid,
  output logic signed [OUT_W-1:0]                           out,
  output logic                                              sat
);

  localparam int ACC_W    = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PROD_W   = DATA_W + COEF_W;
  localparam int RND_W    = ACC_W + 1;
  localparam int EXT_W    = (RND_W > OUT_W) ? RND_W : OUT_W;
  localparam int HALF_BIT = (SHIFT > 0) ? SHIFT - 1 : 0;

  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] x    [TAPS];
  logic signed [PROD_W-1:0] prod [TAPS];
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  tree;
  logic                     v_x;
  logic                     v_p;
  logic                     v_s;
  logic                     do_shift;
  logic                     do_valid;
  logic signed [RND_W-1:0]  half;
  logic signed [RND_W-1:0]  rnd;
  logic signed [RND_W-1:0]  shifted;
  logic signed [EXT_W-1:0]  r_ext;
  logic signed [EXT_W-1:0]  max_v;
  logic signed [EXT_W-1:0]  min_v;
  logic signed [OUT_W-1:0]  out_next;
  logic                     sat_next;

  // wind beats load beats in_valid; only a bare in_valid launches a token
  assign do_shift = !wind && (load || in_valid);
  assign do_valid = !wind && !load && in_valid;

  // Coefficient shift register, fed from the low COEF_W bits of data
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
    end else if (wind) begin
      coef[0] <= data[COEF_W-1:0];
      for (int k = 1; k < TAPS; k++) coef[k] <= coef[k-1];
    end
  end

  // Sample delay line, x[0] holds the newest sample
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
    end else if (do_shift) begin
      x[0] <= data[DATA_W-1:0];
      for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
    end
  end

  // Stage 1: full-precision signed products of the current coef and delay line
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) prod[k] <= PROD_W'(coef[k]) * PROD_W'(x[k]);
    end
  end

  // Adder tree over sign-extended products; ACC_W has enough guard bits
  always_comb begin
    tree = '0;
    for (int k = 0; k < TAPS; k++) tree = tree + ACC_W'(prod[k]);
  end

  // Stage 2: register the accumulated sum
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) sum <= '0;
    else       sum <= tree;
  end

  // Round half toward +inf, arithmetic shift, then clip to the output range
  always_comb begin
    half = '0;
    if (SHIFT > 0) half[HALF_BIT] = 1'b1;
    rnd     = RND_W'(sum) + half;
    shifted = rnd >>> SHIFT;
    r_ext   = EXT_W'(shifted);
    max_v   = '0;
    max_v[OUT_W-1:0] = {1'b0, {(OUT_W-1){1'b1}}};
    min_v   = ~max_v;
    out_next = r_ext[OUT_W-1:0];
    sat_next = 1'b0;
    if (r_ext > max_v) begin
      out_next = max_v[OUT_W-1:0];
      sat_next = 1'b1;
    end else if (r_ext < min_v) begin
      out_next = min_v[OUT_W-1:0];
      sat_next = 1'b1;
    end
  end

  // Valid tokens travel alongside the data through all three stages
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      v_x <= 1'b0;
      v_p <= 1'b0;
      v_s <= 1'b0;
    end else begin
      v_x <= do_valid;
      v_p <= v_x;
      v_s <= v_p;
    end
  end

  // Stage 3: output register; out and sat hold between strobes
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_valid <= 1'b0;
      out       <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= v_s;
      if (v_s) begin
        out <= out_next;
        sat <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_fir_pipe.sv
// tb_fir_pipe: drives three fir_pipe instances (default, SHIFT=2, and a
// small odd-width build) from one shared stimulus stream. A behavioural
// model predicts each accepted sample; predictions are queued and matched
// against the outputs, including exact 3-cycle latency and hold behaviour.
module tb_fir_pipe;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic wind = 1'b0;
  logic load = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0] data = '0;

  logic              ov0, ov1, ov2;
  logic signed [15:0] out0, out1;
  logic signed [9:0]  out2;
  logic              sat0, sat1, sat2;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  int m_taps [3] = '{16, 16, 5};
  int m_dw   [3] = '{16, 16, 8};
  int m_cw   [3] = '{16, 16, 12};
  int m_ow   [3] = '{16, 16, 10};
  int m_sh   [3] = '{0, 2, 3};
  longint m_coef [3][16];
  longint m_x    [3][16];
  longint last_out [3];
  bit     last_sat [3];

  typedef struct {
    int     cycle;
    longint eo0, eo1, eo2;
    bit     es0, es1, es2;
    bit     has_known;
    int     known_idx;
    longint known_out;
    bit     known_sat;
  } sb_entry_t;

  sb_entry_t sbq[$];

  fir_pipe u0 (
    .clk(clk), .rstb(rstb), .wind(wind), .load(load), .in_valid(in_valid),
    .data(data), .out_valid(ov0), .out(out0), .sat(sat0)
  );

  fir_pipe #(.SHIFT(2)) u1 (
    .clk(clk), .rstb(rstb), .wind(wind), .load(load), .in_valid(in_valid),
    .data(data), .out_valid(ov1), .out(out1), .sat(sat1)
  );

  fir_pipe #(.TAPS(5), .DATA_W(8), .COEF_W(12), .OUT_W(10), .SHIFT(3)) u2 (
    .clk(clk), .rstb(rstb), .wind(wind), .load(load), .in_valid(in_valid),
    .data(data[11:0]), .out_valid(ov2), .out(out2), .sat(sat2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  function automatic longint sext(input longint v, input int w);
    longint r;
    r = v & ((longint'(1) <<< w) - 1);
    if (r[w-1]) r = r - (longint'(1) <<< w);
    return r;
  endfunction

  task automatic modelStep(input bit w, input bit l, input bit iv, input logic [15:0] d);
    for (int i = 0; i < 3; i++) begin
      if (w) begin
        for (int k = m_taps[i] - 1; k > 0; k--) m_coef[i][k] = m_coef[i][k-1];
        m_coef[i][0] = sext(longint'(d), m_cw[i]);
      end else if (l || iv) begin
        for (int k = m_taps[i] - 1; k > 0; k--) m_x[i][k] = m_x[i][k-1];
        m_x[i][0] = sext(longint'(d), m_dw[i]);
      end
    end
  endtask

  task automatic modelResult(input int i, output longint o, output bit s);
    longint acc, r, maxv, minv;
    acc = 0;
    for (int k = 0; k < m_taps[i]; k++) acc += m_coef[i][k] * m_x[i][k];
    if (m_sh[i] > 0) r = (acc + (longint'(1) <<< (m_sh[i] - 1))) >>> m_sh[i];
    else             r = acc;
    maxv = (longint'(1) <<< (m_ow[i] - 1)) - 1;
    minv = -maxv - 1;
    s = 1'b1;
    if (r > maxv)      o = maxv;
    else if (r < minv) o = minv;
    else begin
      o = r;
      s = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit w, input bit l, input bit iv, input logic [15:0] d,
                               input bit has_known = 1'b0, input int kidx = 0,
                               input longint kout = 0, input bit ksat = 1'b0);
    sb_entry_t e;
    wind = w;
    load = l;
    in_valid = iv;
    data = d;
    @(posedge clk);
    #1;
    modelStep(w, l, iv, d);
    if (!w && !l && iv) begin
      e.cycle = cycle;
      modelResult(0, e.eo0, e.es0);
      modelResult(1, e.eo1, e.es1);
      modelResult(2, e.eo2, e.es2);
      e.has_known = has_known;
      e.known_idx = kidx;
      e.known_out = kout;
      e.known_sat = ksat;
      sbq.push_back(e);
    end
    wind = 1'b0;
    load = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rstb = 1'b0;
    #1;
    checkOutput("rst_valid0", longint'(ov0), 0);
    checkOutput("rst_valid1", longint'(ov1), 0);
    checkOutput("rst_valid2", longint'(ov2), 0);
    checkOutput("rst_out0", longint'(out0), 0);
    checkOutput("rst_out2", longint'(out2), 0);
    checkOutput("rst_sat1", longint'(sat1), 0);
    sbq.delete();
    for (int i = 0; i < 3; i++) begin
      last_out[i] = 0;
      last_sat[i] = 1'b0;
      for (int k = 0; k < 16; k++) begin
        m_coef[i][k] = 0;
        m_x[i][k] = 0;
      end
    end
    @(posedge clk);
    #2;
    rstb = 1'b1;
  endtask

  // Output monitor: every cycle checks strobes, and either the popped
  // prediction or that out/sat held their previous values
  always @(negedge clk) begin
    bit exp_v;
    sb_entry_t e;
    if (rstb) begin
      exp_v = (sbq.size() > 0) && (sbq[0].cycle + 3 == cycle);
      checkOutput("valid0", longint'(ov0), longint'(exp_v));
      checkOutput("valid1", longint'(ov1), longint'(exp_v));
      checkOutput("valid2", longint'(ov2), longint'(exp_v));
      if (exp_v) begin
        e = sbq.pop_front();
        checkOutput("out0", longint'(out0), e.eo0);
        checkOutput("out1", longint'(out1), e.eo1);
        checkOutput("out2", longint'(out2), e.eo2);
        checkOutput("sat0", longint'(sat0), longint'(e.es0));
        checkOutput("sat1", longint'(sat1), longint'(e.es1));
        checkOutput("sat2", longint'(sat2), longint'(e.es2));
        if (e.has_known) begin
          case (e.known_idx)
            0: begin
              checkOutput("known_out0", longint'(out0), e.known_out);
              checkOutput("known_sat0", longint'(sat0), longint'(e.known_sat));
            end
            1: begin
              checkOutput("known_out1", longint'(out1), e.known_out);
              checkOutput("known_sat1", longint'(sat1), longint'(e.known_sat));
            end
            default: begin
              checkOutput("known_out2", longint'(out2), e.known_out);
              checkOutput("known_sat2", longint'(sat2), longint'(e.known_sat));
            end
          endcase
        end
        last_out[0] = e.eo0;
        last_out[1] = e.eo1;
        last_out[2] = e.eo2;
        last_sat[0] = e.es0;
        last_sat[1] = e.es1;
        last_sat[2] = e.es2;
      end else begin
        checkOutput("hold_out0", longint'(out0), last_out[0]);
        checkOutput("hold_out1", longint'(out1), last_out[1]);
        checkOutput("hold_out2", longint'(out2), last_out[2]);
        checkOutput("hold_sat0", longint'(sat0), longint'(last_sat[0]));
        checkOutput("hold_sat2", longint'(sat2), longint'(last_sat[2]));
      end
    end
  end

  initial begin
    int mode;
    logic [15:0] d;

    resetDut();

    // Unity coefficients over a ramp
    $display("[TB] ramp with unity coefficients");
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 16'd1);
    for (int i = 1; i <= 16; i++) applyStimulus(0, 1, 0, 16'(i));
    applyStimulus(0, 0, 1, 16'd16, 1, 0, 151, 0);
    applyStimulus(0, 0, 1, 16'd16, 1, 0, 165, 0);
    applyStimulus(0, 0, 1, 16'd16, 1, 0, 178, 0);
    idleCycles(5);

    // Positive and negative clipping
    $display("[TB] saturation");
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 16'h7FFF);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 16'h7FFF);
    applyStimulus(0, 0, 1, 16'h7FFF, 1, 0, 32767, 1);
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 16'h8000);
    applyStimulus(0, 0, 1, 16'h8000, 1, 0, -32768, 1);
    idleCycles(5);

    // Rounding on the SHIFT=2 instance with a single unity tap at coef[0]
    $display("[TB] rounding");
    for (int i = 0; i < 15; i++) applyStimulus(1, 0, 0, 16'd0);
    applyStimulus(1, 0, 0, 16'd1);
    applyStimulus(0, 0, 1, 16'd6, 1, 1, 2, 0);
    applyStimulus(0, 0, 1, 16'hFFFA, 1, 1, -1, 0);
    applyStimulus(0, 0, 1, 16'd5, 1, 1, 1, 0);
    idleCycles(5);

    // Priority: wind and load swallow a simultaneous in_valid
    $display("[TB] priority");
    applyStimulus(0, 0, 1, 16'd7, 1, 1, 2, 0);
    applyStimulus(1, 0, 1, 16'd9);
    applyStimulus(0, 1, 1, 16'd11);
    applyStimulus(0, 0, 1, 16'd3, 1, 1, 10, 0);
    idleCycles(5);

    // Asynchronous reset while two samples are in flight
    $display("[TB] reset mid-flight");
    applyStimulus(0, 0, 1, 16'd1);
    applyStimulus(0, 0, 1, 16'd2);
    resetDut();
    idleCycles(4);
    applyStimulus(0, 0, 1, 16'd100, 1, 0, 0, 0);
    idleCycles(5);

    // Random traffic with full-range and small-magnitude data
    $display("[TB] random traffic");
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 16'($urandom));
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 16'($urandom));
    for (int i = 0; i < 400; i++) begin
      mode = int'($urandom_range(0, 15));
      if (i < 250) d = 16'($urandom);
      else         d = 16'(int'($urandom_range(0, 40)) - 20);
      case (mode)
        0:       applyStimulus(1, 0, 0, d);
        1:       applyStimulus(0, 1, 0, d);
        2:       applyStimulus(1, 0, 1, d);
        3:       applyStimulus(0, 1, 1, d);
        4:       idleCycles(1);
        default: applyStimulus(0, 0, 1, d);
      endcase
    end
    idleCycles(6);
    checkOutput("drain", longint'(sbq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
